// File: rtl/fpu_pkg.sv
// fpu_pkg: shared opcode/funct3 constants and LSU state encoding for the FP load/store unit
package fpu_pkg;
    localparam logic [6:0] OP_LOAD_FP  = 7'h07;
    localparam logic [6:0] OP_STORE_FP = 7'h27;
    localparam logic [2:0] F3_W        = 3'h2;
    localparam logic [2:0] F3_D        = 3'h3;
    typedef enum logic [1:0] {IDLE, LO, HI, WB} lsu_state_t;
endpackage

// File: rtl/fpu_lsu.sv
// fpu_lsu: FP load/store unit executing FLW/FLD/FSW/FSD over a 32-bit single-outstanding bus.
// Ports: clk/rst (async active-low); issue i_valid/o_ready with i_ops, i_funct3, i_rd_a,
// i_addr, i_fsdata; memory bus o_mem_req/o_mem_we/o_mem_addr/o_mem_wdata, i_mem_ack/i_mem_rdata;
// FP regfile write o_rd_en/o_rd_a/o_rd_data; drop pulses o_misalign/o_illegal.
module fpu_lsu
    import fpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [6:0]        i_ops,
    input  logic [2:0]        i_funct3,
    input  logic [4:0]        i_rd_a,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [63:0]       i_fsdata,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [31:0]       i_mem_rdata,
    output logic              o_rd_en,
    output logic [4:0]        o_rd_a,
    output logic [63:0]       o_rd_data,
    output logic              o_misalign,
    output logic              o_illegal
);
    lsu_state_t        state, next;
    logic              is_load, is_d;
    logic [4:0]        rd;
    logic [ADDR_W-1:0] addr;
    logic [63:0]       fsdata, cap;
    logic              accept, bad_op, bad_align;

    assign accept    = i_valid && (state == IDLE);
    assign bad_op    = !((i_ops == OP_LOAD_FP || i_ops == OP_STORE_FP) &&
                         (i_funct3 == F3_W || i_funct3 == F3_D));
    assign bad_align = (i_funct3 == F3_D) ? |i_addr[2:0] : |i_addr[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next;
    end

    always_comb begin
        next        = state;
        o_ready     = state == IDLE;
        o_mem_req   = state == LO || state == HI;
        o_mem_we    = o_mem_req && !is_load;
        o_mem_addr  = state == HI ? addr + ADDR_W'(4) : state == LO ? addr : '0;
        o_mem_wdata = !o_mem_we ? 32'h0 : state == HI ? fsdata[63:32] : fsdata[31:0];
        o_rd_en     = state == WB;
        o_rd_a      = o_rd_en ? rd : 5'h0;
        o_rd_data   = !o_rd_en ? 64'h0 : is_d ? cap : {32'h0, cap[31:0]};
        case (state)
            IDLE:    if (accept && !bad_op && !bad_align) next = LO;
            LO:      if (i_mem_ack) next = is_d ? HI : is_load ? WB : IDLE;
            HI:      if (i_mem_ack) next = is_load ? WB : IDLE;
            default: next = IDLE;
        endcase
    end

    // Capture is cleared by reset so an aborted load leaves no partial data behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_illegal  <= 1'b0;
            o_misalign <= 1'b0;
            is_load    <= 1'b0;
            is_d       <= 1'b0;
            rd         <= '0;
            addr       <= '0;
            fsdata     <= '0;
            cap        <= '0;
        end else begin
            o_illegal  <= accept && bad_op;
            o_misalign <= accept && !bad_op && bad_align;
            if (accept) begin
                is_load <= i_ops == OP_LOAD_FP;
                is_d    <= i_funct3 == F3_D;
                rd      <= i_rd_a;
                addr    <= i_addr;
                fsdata  <= i_fsdata;
            end
            if (state == LO && i_mem_ack) cap[31:0]  <= i_mem_rdata;
            if (state == HI && i_mem_ack) cap[63:32] <= i_mem_rdata;
        end
    end
endmodule

// File: tb/tb_fpu_lsu.sv
// tb_fpu_lsu: self-checking bench for fpu_lsu with a word-addressed memory model and directed/random ops
module tb_fpu_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [6:0]  i_ops = '0;
    logic [2:0]  i_funct3 = '0;
    logic [4:0]  i_rd_a = '0;
    logic [31:0] i_addr = '0;
    logic [63:0] i_fsdata = '0;
    logic        o_mem_req, o_mem_we;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        o_rd_en;
    logic [4:0]  o_rd_a;
    logic [63:0] o_rd_data;
    logic        o_misalign, o_illegal;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [logic [31:0]];

    fpu_lsu #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_ops(i_ops), .i_funct3(i_funct3), .i_rd_a(i_rd_a), .i_addr(i_addr),
        .i_fsdata(i_fsdata), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack),
        .i_mem_rdata(i_mem_rdata), .o_rd_en(o_rd_en), .o_rd_a(o_rd_a),
        .o_rd_data(o_rd_data), .o_misalign(o_misalign), .o_illegal(o_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"}, o_ready, 1);
        chk({tag, "_req"}, o_mem_req, 0);
        chk({tag, "_we"}, o_mem_we, 0);
        chk({tag, "_rd_en"}, o_rd_en, 0);
        chk({tag, "_misalign"}, o_misalign, 0);
        chk({tag, "_illegal"}, o_illegal, 0);
        chk({tag, "_mem_addr"}, o_mem_addr, 0);
        chk({tag, "_wdata"}, o_mem_wdata, 0);
        chk({tag, "_rd_a"}, o_rd_a, 0);
        chk({tag, "_rd_data"}, o_rd_data, 0);
    endtask

    // Entered and left at a falling edge; issues one request and plays the memory side.
    task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] a, input logic [63:0] fsd, input int waits);
        logic        legal, mis, ld, dbl;
        logic [31:0] ba;
        logic [31:0] w [2];
        logic [63:0] exp;
        int          nb;
        legal = (op == 7'h07 || op == 7'h27) && (f3 == 3'h2 || f3 == 3'h3);
        dbl   = f3 == 3'h3;
        ld    = op == 7'h07;
        mis   = dbl ? (a % 8 != 0) : (a % 4 != 0);
        w[0]  = '0;
        w[1]  = '0;
        chk("ready_at_issue", o_ready, 1);
        i_valid  = 1'b1;
        i_ops    = op;
        i_funct3 = f3;
        i_rd_a   = rd;
        i_addr   = a;
        i_fsdata = fsd;
        @(negedge clk);
        i_valid  = 1'b0;
        i_ops    = 7'($urandom);
        i_funct3 = 3'($urandom);
        i_rd_a   = 5'($urandom);
        i_addr   = $urandom;
        i_fsdata = {$urandom, $urandom};
        chk("illegal_pulse", o_illegal, !legal);
        chk("misalign_pulse", o_misalign, legal && mis);
        if (!legal || mis) begin
            chk("drop_no_req", o_mem_req, 0);
            chk("drop_ready", o_ready, 1);
            return;
        end
        nb = dbl ? 2 : 1;
        for (int b = 0; b < nb; b++) begin
            ba = a + 32'(4 * b);
            if (ld && !mem.exists(ba)) mem[ba] = $urandom;
            for (int k = 0; k <= waits; k++) begin
                chk("req", o_mem_req, 1);
                chk("beat_addr", o_mem_addr, ba);
                chk("beat_we", o_mem_we, !ld);
                if (!ld) chk("beat_wdata", o_mem_wdata, b == 1 ? fsd[63:32] : fsd[31:0]);
                chk("rd_en_during_bus", o_rd_en, 0);
                if (k == waits) begin
                    if (!ld) mem[ba] = b == 1 ? fsd[63:32] : fsd[31:0];
                    w[b]        = mem[ba];
                    i_mem_ack   = 1'b1;
                    i_mem_rdata = ld ? mem[ba] : $urandom;
                end else begin
                    i_mem_rdata = $urandom;
                end
                @(negedge clk);
                i_mem_ack = 1'b0;
            end
        end
        if (ld) begin
            exp = dbl ? {w[1], w[0]} : {32'h0, w[0]};
            chk("wb_rd_en", o_rd_en, 1);
            chk("wb_rd_a", o_rd_a, rd);
            chk("wb_rd_data", o_rd_data, exp);
            chk("wb_no_req", o_mem_req, 0);
            // A stray ack outside the bus states must be ignored.
            i_mem_ack   = 1'b1;
            i_mem_rdata = $urandom;
            @(negedge clk);
            i_mem_ack = 1'b0;
        end
        chk("done_ready", o_ready, 1);
        chk("done_rd_en", o_rd_en, 0);
        chk("done_req", o_mem_req, 0);
    endtask

    initial begin
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] a;
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("post_reset");

        mem[32'h100] = 32'h00000000;
        mem[32'h104] = 32'h3FF00000;
        run_op(7'h07, 3'h3, 5'd5, 32'h100, 64'h0, 0);
        mem[32'h200] = 32'h40490FDB;
        run_op(7'h07, 3'h2, 5'd9, 32'h200, 64'h0, 3);
        run_op(7'h27, 3'h3, 5'd0, 32'h300, 64'h1122334455667788, 1);
        run_op(7'h07, 3'h3, 5'd12, 32'h300, 64'h0, 0);
        run_op(7'h27, 3'h2, 5'd0, 32'h308, 64'hDEADBEEF_CAFEF00D, 0);
        run_op(7'h07, 3'h2, 5'd13, 32'h308, 64'h0, 2);

        run_op(7'h07, 3'h3, 5'd1, 32'h104, 64'h0, 0);
        run_op(7'h07, 3'h1, 5'd1, 32'h100, 64'h0, 0);
        run_op(7'h13, 3'h2, 5'd1, 32'h101, 64'h0, 0);
        run_op(7'h07, 3'h2, 5'd2, 32'h200, 64'h0, 0);
        run_op(7'h27, 3'h2, 5'd2, 32'h202, 64'h0, 0);

        run_op(7'h07, 3'h3, 5'd3, 32'hFFFFFFF8, 64'h0, 2);
        run_op(7'h07, 3'h3, 5'd3, 32'hFFFFFFFC, 64'h0, 0);
        run_op(7'h27, 3'h3, 5'd0, 32'hFFFFFFF8, 64'h0123456789ABCDEF, 0);

        i_valid  = 1'b1;
        i_ops    = 7'h07;
        i_funct3 = 3'h3;
        i_rd_a   = 5'd7;
        i_addr   = 32'h400;
        @(negedge clk);
        i_valid     = 1'b0;
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'hAAAA5555;
        @(negedge clk);
        i_mem_ack = 1'b0;
        chk("abort_hi_req", o_mem_req, 1);
        chk("abort_hi_addr", o_mem_addr, 32'h404);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_req_async", o_mem_req, 0);
        chk("abort_ready_async", o_ready, 1);
        @(negedge clk);
        chk_idle_outputs("abort_reset");
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_rd_en", o_rd_en, 0);
            chk("abort_no_req", o_mem_req, 0);
        end
        chk("abort_ready_after", o_ready, 1);

        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: op = 7'h07;
                4, 5, 6, 7: op = 7'h27;
                default:    op = 7'($urandom);
            endcase
            f3 = $urandom_range(0, 9) < 9 ? 3'($urandom_range(2, 3)) : 3'($urandom_range(0, 7));
            a  = 32'h1000 + 32'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            run_op(op, f3, 5'($urandom), a, {$urandom, $urandom}, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
